inv_shift_rows_stream: RTL and testbench

//  Byte-serial (Inv)ShiftRows reorder unit for the AES datapath. Accepts 16-byte AES states as a

---
 rtl/aes_pkg.sv | 24 ++
 rtl/stream_pingpong_ctrl.sv | 101 ++++++++++
 rtl/inv_shift_rows_stream.sv | 64 ++++++
 tb/tb_inv_shift_rows_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte type and the one ShiftRows/InvShiftRows
// permutation used by every byte-serial and combinational user.
package aes_pkg;

   localparam int AES_STATE_BYTES = 16;
   localparam int AES_IDX_W       = 4;

   typedef logic [7:0]           aes_byte_t;
   typedef logic [AES_IDX_W-1:0] aes_idx_t;

   localparam aes_idx_t AES_LAST_IDX = aes_idx_t'(AES_STATE_BYTES - 1);

   // Output index k = 4*col + row takes its byte from column (col -/+ row) mod 4, same row.
   function automatic aes_idx_t shift_rows_src(input aes_idx_t k, input logic inv);
      logic [1:0] row;
      logic [1:0] col;
      logic [1:0] src_col;
      row     = k[1:0];
      col     = k[3:2];
      src_col = inv ? (col - row) : (col + row);
      return {src_col, row};
   endfunction

endpackage

// File: rtl/stream_pingpong_ctrl.sv
// Ping-pong bookkeeping for a two-bank 16-beat buffer: full flags, bank selects,
// beat counters, ready/valid handshakes and the registered framing-error pulse.
module stream_pingpong_ctrl
   import aes_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     in_valid_i,
   input  logic     in_last_i,
   input  logic     out_ready_i,
   output logic     in_ready_o,
   output logic     out_valid_o,
   output logic     out_last_o,
   output logic     wr_en_o,
   output logic     wr_sel_o,
   output aes_idx_t wr_cnt_o,
   output logic     rd_sel_o,
   output aes_idx_t rd_cnt_o,
   output logic     err_o
);

   logic [1:0] full_q,   full_d;
   logic       wr_sel_q, wr_sel_d;
   logic       rd_sel_q, rd_sel_d;
   aes_idx_t   wr_cnt_q, wr_cnt_d;
   aes_idx_t   rd_cnt_q, rd_cnt_d;
   logic       err_q,    err_d;

   logic accept;
   logic consume;

   // Held low throughout reset even though the cleared flags alone would read as ready.
   assign in_ready_o  = ~full_q[wr_sel_q] & ~rst;
   assign out_valid_o = full_q[rd_sel_q];
   assign out_last_o  = out_valid_o & (rd_cnt_q == AES_LAST_IDX);

   assign accept  = in_valid_i & in_ready_o;
   assign consume = out_valid_o & out_ready_i;

   assign wr_en_o  = accept;
   assign wr_sel_o = wr_sel_q;
   assign wr_cnt_o = wr_cnt_q;
   assign rd_sel_o = rd_sel_q;
   assign rd_cnt_o = rd_cnt_q;
   assign err_o    = err_q;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path can leave one unassigned (no latch).
      full_d   = full_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      err_d    = 1'b0;

      if (accept) begin
         if (wr_cnt_q == AES_LAST_IDX) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
            wr_cnt_d         = '0;
            err_d            = ~in_last_i;
         end else if (in_last_i) begin
            wr_cnt_d = '0;
            err_d    = 1'b1;
         end else begin
            wr_cnt_d = wr_cnt_q + 4'd1;
         end
      end

      // Filling and draining always target different banks, so both updates can coexist.
      if (consume) begin
         if (rd_cnt_q == AES_LAST_IDX) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            rd_cnt_d         = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 4'd1;
         end
      end
   end

   // NOTE: registered state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q   <= '0;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         full_q   <= full_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial (Inv)ShiftRows reorder: two 16-byte banks written in arrival order and
// read back through the row-rotation permutation, 1 byte/cycle sustained.
module inv_shift_rows_stream
   import aes_pkg::*;
#(
   parameter int MODE = 1,
   parameter int DW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          err
);

   if (DW != 8) begin : g_bad_dw
      $error("inv_shift_rows_stream: DW must be 8");
   end

   localparam logic INV = (MODE != 0);

   logic     wr_en;
   logic     wr_sel;
   logic     rd_sel;
   aes_idx_t wr_cnt;
   aes_idx_t rd_cnt;
   aes_idx_t rd_src;

   logic [DW-1:0] bank_q [2][AES_STATE_BYTES];

   stream_pingpong_ctrl u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_last_i   (in_last),
      .out_ready_i (out_ready),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_last_o  (out_last),
      .wr_en_o     (wr_en),
      .wr_sel_o    (wr_sel),
      .wr_cnt_o    (wr_cnt),
      .rd_sel_o    (rd_sel),
      .rd_cnt_o    (rd_cnt),
      .err_o       (err)
   );

   // NOTE: the banks carry no reset; out_data is gated by out_valid so stale contents never leak.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         bank_q[wr_sel][wr_cnt] <= in_data;
      end
   end

   assign rd_src   = shift_rows_src(rd_cnt, INV);
   assign out_data = out_valid ? bank_q[rd_sel][rd_src] : '0;

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Drives an inverse and a forward instance with the same stream and checks both against
// a state-level model (matrix row rotation, count of buffered states).
module tb_inv_shift_rows_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       rdy_inv, ov_inv, ol_inv, err_inv;
   logic       rdy_fwd, ov_fwd, ol_fwd, err_fwd;
   logic [7:0] od_inv, od_fwd;

   always #5 clk = ~clk;

   inv_shift_rows_stream #(.MODE(1), .DW(8)) dut_inv (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_inv), .in_data(in_data),
      .in_last(in_last), .out_valid(ov_inv), .out_ready(out_ready), .out_data(od_inv),
      .out_last(ol_inv), .err(err_inv));

   inv_shift_rows_stream #(.MODE(0), .DW(8)) dut_fwd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_fwd), .in_data(in_data),
      .in_last(in_last), .out_valid(ov_fwd), .out_ready(out_ready), .out_data(od_fwd),
      .out_last(ol_fwd), .err(err_fwd));

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] tx_q[$];
   logic [7:0] part[$];
   logic [7:0] exp_inv[$], exp_fwd[$];
   logic [7:0] log_inv[$], log_fwd[$];
   int         pending = 0;
   int         drained = 0;
   int         vp = 100;
   int         rp = 100;
   logic       exp_err = 1'b0;

   logic [7:0] t1_inv[16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                              8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
   logic [7:0] t1_fwd[16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                              8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
   logic [7:0] t3_inv[4]  = '{8'h10, 8'h1D, 8'h1A, 8'h17};
   logic [7:0] t5_inv[3]  = '{8'h20, 8'h2D, 8'h2A};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      in_valid = (tx_q.size() > 0) && ($urandom_range(99) < vp);
      if (tx_q.size() > 0) {in_last, in_data} = tx_q[0];
      else begin
         in_last = 1'b0;
         in_data = 8'($urandom);
      end
      out_ready = ($urandom_range(99) < rp);
   endtask

   // Rows of the 4x4 state rotate: inverse takes column (c-r), forward column (c+r).
   task automatic emit_state();
      logic [7:0] m[4][4];
      for (int k = 0; k < 16; k++) m[k % 4][k / 4] = part[k];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            exp_inv.push_back(m[r][(c - r + 4) % 4]);
            exp_fwd.push_back(m[r][(c + r) % 4]);
         end
      end
   endtask

   task automatic step();
      bit acc, cons, new_err;
      int inc, dec;
      @(negedge clk);
      check("in_ready_inv", rdy_inv, pending < 2);
      check("in_ready_fwd", rdy_fwd, pending < 2);
      check("out_valid_inv", ov_inv, pending > 0);
      check("out_valid_fwd", ov_fwd, pending > 0);
      check("err_inv", err_inv, exp_err);
      check("err_fwd", err_fwd, exp_err);
      acc = in_valid && (pending < 2);
      cons = out_ready && (pending > 0);
      inc = 0; dec = 0; new_err = 1'b0;
      if (cons) begin
         check("out_data_inv", od_inv, exp_inv[0]);
         check("out_data_fwd", od_fwd, exp_fwd[0]);
         check("out_last_inv", ol_inv, drained == 15);
         check("out_last_fwd", ol_fwd, drained == 15);
         log_inv.push_back(od_inv);
         log_fwd.push_back(od_fwd);
         void'(exp_inv.pop_front());
         void'(exp_fwd.pop_front());
         drained++;
         if (drained == 16) begin
            drained = 0;
            dec = 1;
         end
      end
      if (acc) begin
         void'(tx_q.pop_front());
         part.push_back(in_data);
         if (part.size() == 16) begin
            emit_state();
            part.delete();
            inc = 1;
            new_err = !in_last;
         end else if (in_last) begin
            part.delete();
            new_err = 1'b1;
         end
      end
      pending += inc - dec;
      exp_err = new_err;
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 4000 && !(tx_q.size() == 0 && pending == 0); i++) step();
      if (!(tx_q.size() == 0 && pending == 0)) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic push_state(input logic [7:0] base, input logic last_ok);
      for (int i = 0; i < 16; i++) tx_q.push_back({(i == 15) ? last_ok : 1'b0, 8'(base + i)});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      #1;
      check("rst_in_ready", rdy_inv | rdy_fwd, 0);
      check("rst_out_valid", ov_inv | ov_fwd, 0);
      check("rst_out_last", ol_inv | ol_fwd, 0);
      check("rst_err", err_inv | err_fwd, 0);
      check("rst_out_data", {od_inv, od_fwd}, 0);
      tx_q.delete(); part.delete(); exp_inv.delete(); exp_fwd.delete();
      pending = 0; drained = 0; exp_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_in_ready", {rdy_inv, rdy_fwd}, 2'b11);
      @(posedge clk);
      #1;
      drive();
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      do_reset();

      // Single state, both directions, full throughput.
      vp = 100; rp = 100;
      log_inv.delete(); log_fwd.delete();
      push_state(8'h00, 1'b1);
      wait_idle("t1");
      check("t1_len", log_inv.size(), 16);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("t1_inv[%0d]", k), log_inv[k], t1_inv[k]);
         check($sformatf("t1_fwd[%0d]", k), log_fwd[k], t1_fwd[k]);
      end

      // Four states back to back.
      log_inv.delete(); log_fwd.delete();
      for (int s = 0; s < 4; s++) push_state(8'(s * 16), 1'b1);
      wait_idle("t3");
      check("t3_len", log_inv.size(), 64);
      for (int k = 0; k < 4; k++) check($sformatf("t3_inv[%0d]", k), log_inv[16 + k], t3_inv[k]);

      // Output stalled: both banks fill, third state waits.
      rp = 0;
      for (int s = 0; s < 3; s++) push_state(8'(8'h40 + s * 16), 1'b1);
      run(60);
      rp = 100;
      wait_idle("t4");

      // Framing: short state dropped, then good state, then beat 15 without in_last.
      log_inv.delete(); log_fwd.delete();
      for (int i = 0; i < 5; i++) tx_q.push_back({(i == 4), 8'(8'h50 + i)});
      push_state(8'h20, 1'b1);
      push_state(8'h60, 1'b0);
      wait_idle("t5");
      check("t5_len", log_inv.size(), 32);
      for (int k = 0; k < 3; k++) check($sformatf("t5_inv[%0d]", k), log_inv[k], t5_inv[k]);

      // Reset in the middle of a drain with the other bank full.
      rp = 0;
      push_state(8'h70, 1'b1);
      push_state(8'h80, 1'b1);
      for (n = 0; n < 200 && pending < 2; n++) step();
      rp = 100;
      for (n = 0; n < 200 && !(pending == 2 && drained == 7); n++) step();
      if (!(pending == 2 && drained == 7)) check("t6_setup_timeout", 0, 1);
      do_reset();
      log_inv.delete(); log_fwd.delete();
      run(20);
      check("t6_no_output", log_inv.size(), 0);
      push_state(8'h90, 1'b1);
      wait_idle("t6");
      check("t6_len", log_inv.size(), 16);
      check("t6_first", log_inv[0], 8'h90);

      // Randomized traffic with occasional framing errors.
      for (int s = 0; s < 150; s++) begin
         int kind;
         vp = $urandom_range(100, 20);
         rp = $urandom_range(100, 20);
         kind = $urandom_range(7);
         if (kind == 0) begin
            n = $urandom_range(15, 1);
            for (int i = 0; i < n; i++) tx_q.push_back({(i == n - 1), 8'($urandom)});
         end else begin
            for (int i = 0; i < 16; i++)
               tx_q.push_back({(i == 15) ? (kind != 1) : 1'b0, 8'($urandom)});
         end
         run($urandom_range(40, 8));
         if (s % 10 == 9) wait_idle("rand");
      end
      wait_idle("rand_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
